// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage with PC register and IF/ID pipeline register.
// Optional stall-cycle counter enabled by defining IF_STAGE_STALL_COUNTER_EN.
module if_stage_pipe #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite_i,
    input  logic        IF_ID_Write_i,
    input  logic        IF_Flush_i,
    input  logic [31:0] BranchTarget_i,
    input  logic [31:0] Instruction_i,
    output logic [31:0] PC_o,
    output logic [31:0] IF_ID_PC4_o,
    output logic [31:0] IF_ID_Instruction_o,
    output logic        IF_ID_Valid_o,
    output logic [15:0] StallCount_o
);

    logic [31:0] pc_p0;
    logic [31:0] pc4_p0;
    logic [31:0] instr_p1;
    logic [31:0] pc4_p1;
    logic        vld_p1;
    logic        flush_q;

    // A stall on either enable suppresses the flush; the flush is retried
    // naturally because the ID stage keeps asserting it.
    assign flush_q = IF_Flush_i & PCWrite_i & IF_ID_Write_i;
    assign pc4_p0  = pc_p0 + 32'd4;

    // ---- stage p0: fetch PC ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_p0 <= RESET_PC;
        end else if (flush_q) begin
            pc_p0 <= BranchTarget_i & 32'hFFFF_FFFC;
        end else if (PCWrite_i) begin
            pc_p0 <= pc4_p0;
        end
    end

    // ---- stage p1: IF/ID register ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_p1 <= 32'h0000_0000;
            pc4_p1   <= 32'h0000_0000;
            vld_p1   <= 1'b0;
        end else if (flush_q) begin
            instr_p1 <= 32'h0000_0000;
            pc4_p1   <= 32'h0000_0000;
            vld_p1   <= 1'b0;
        end else if (IF_ID_Write_i) begin
            instr_p1 <= Instruction_i;
            pc4_p1   <= pc4_p0;
            vld_p1   <= 1'b1;
        end
    end

    assign PC_o                = pc_p0;
    assign IF_ID_PC4_o         = pc4_p1;
    assign IF_ID_Instruction_o = instr_p1;
    assign IF_ID_Valid_o       = vld_p1;

`ifdef IF_STAGE_STALL_COUNTER_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_cnt_p1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_p1 <= 16'h0000;
        end else if (!PCWrite_i) begin
            stall_cnt_p1 <= sat_inc16(stall_cnt_p1);
        end
    end

    assign StallCount_o = stall_cnt_p1;
`else
    assign StallCount_o = 16'h0000;
`endif

endmodule

// File: doc/if_stage_pipe.md
IF_STAGE_PIPE -- requirements
Module: if_stage_pipe

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0040_0000, the PC value loaded on reset.
REQ-002 The block SHALL have port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset: input, 1 bit; reset is synchronous and active-low.
REQ-004 The block SHALL have port PCWrite_i: input, 1 bit, PC enable from the hazard detection unit; 0 = hold.
REQ-005 The block SHALL have port IF_ID_Write_i: input, 1 bit, IF/ID register enable from the hazard detection unit; 0 = hold.
REQ-006 The block SHALL have port IF_Flush_i: input, 1 bit, taken branch/jump resolved in ID; squash fetched instruction and redirect.
REQ-007 The block SHALL have port BranchTarget_i: input, 32 bits, redirect address valid when IF_Flush_i=1.
REQ-008 The block SHALL have port Instruction_i: input, 32 bits, instruction memory read data for address PC_o, combinational.
REQ-009 The block SHALL have port PC_o: output, 32 bits, current fetch address to instruction memory.
REQ-010 The block SHALL have port IF_ID_PC4_o: output, 32 bits, registered PC+4 of the instruction in ID.
REQ-011 The block SHALL have port IF_ID_Instruction_o: output, 32 bits, registered instruction in ID; its [25:21]/[20:16] fields feed the hazard unit's rs/rt.
REQ-012 The block SHALL have port IF_ID_Valid_o: output, 1 bit; 1 = IF/ID holds a real instruction, 0 = bubble.
REQ-013 The block SHALL have port StallCount_o: output, 16 bits, stall-cycle counter (see Configuration).

Function
REQ-014 PC+4 SHALL be computed combinationally as PC_o + 32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-015 Define flush_q = IF_Flush_i AND PCWrite_i AND IF_ID_Write_i; a stall always wins over a flush.
REQ-016 The next PC SHALL be selected in this priority order: flush_q loads {BranchTarget_i[31:2],2'b00}; else PCWrite_i=1 loads PC+4; else PC is held.
REQ-017 On flush_q, the IF/ID register SHALL load instruction 32'h0000_0000 (NOP), PC4 32'h0, and valid 0, in the same edge as the redirect.
REQ-018 Otherwise, when IF_ID_Write_i=1, the IF/ID register SHALL load Instruction_i, PC+4, and valid 1.
REQ-019 When IF_ID_Write_i=0, the IF/ID register SHALL hold all three fields unchanged.
REQ-020 PCWrite_i and IF_ID_Write_i SHALL act independently when they differ; no cross-blocking beyond REQ-015.
REQ-021 Latency SHALL be one cycle: an instruction fetched at PC in cycle N appears on IF_ID_* in cycle N+1 if enabled.
REQ-022 A held IF_Flush_i during a stall SHALL take effect on the first cycle both enables are 1; the block stores no pending-flush state.
REQ-023 All outputs SHALL be driven from registers only; there SHALL be no combinational path from any input to any output.

Reset
REQ-024 When reset=0 at a rising edge, the block SHALL set PC_o=RESET_PC, IF_ID_Instruction_o=0, IF_ID_PC4_o=0, IF_ID_Valid_o=0, StallCount_o=0.
REQ-025 Reset SHALL override all other inputs, including mid-stall and mid-flush.
REQ-026 On the first edge after reset=1, normal fetch SHALL resume from RESET_PC.

Configuration
REQ-027 With macro IF_STAGE_STALL_COUNTER_EN defined, StallCount_o SHALL increment by 1 on every non-reset edge with PCWrite_i=0, saturate at 16'hFFFF, and never wrap.
REQ-028 With IF_STAGE_STALL_COUNTER_EN undefined, StallCount_o SHALL be constant 16'h0000 and no counter flops SHALL be synthesised.

Verification
REQ-029 Hold reset=0 for 2 cycles, then release; PC_o SHALL read 0x00400000, 0x00400004, 0x00400008, and IF_ID_Valid_o SHALL go to 1 one cycle after release.
REQ-030 Apply a load-use stall: PCWrite_i=IF_ID_Write_i=0 for 1 cycle at PC=0x00400008; PC SHALL hold at 0x00400008 and IF/ID SHALL hold, then advance to 0x0040000C.
REQ-031 Apply a flush: IF_Flush_i=1 with BranchTarget_i=0x00400100 and both enables 1; next edge SHALL give PC_o=0x00400100, IF_ID_Instruction_o=0, and IF_ID_Valid_o=0.
REQ-032 Apply flush and stall together: IF_Flush_i=1 and PCWrite_i=0 for 1 cycle, then enables=1 with flush still 1; redirect SHALL occur only on the second edge.
REQ-033 Apply wrap and alignment: set PC=0xFFFFFFFC via flush to 0xFFFFFFFF; PC_o SHALL be 0xFFFFFFFC, then 0x00000000.
REQ-034 With IF_STAGE_STALL_COUNTER_EN defined, apply 70000 stall cycles; StallCount_o SHALL be 0xFFFF, and SHALL return to 0 on reset=0.
